// File: rtl/pc_epc_unit.sv
// PC register stage with exception entry sequencing (EPC save, vector fetch, PC load).
// Optional misaligned-target trap enabled by defining PC_MISALIGN_EN.
module pc_epc_unit #(
    parameter int EXC_BASE = 253,
    parameter int MEM_LAT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mux_pc_source_out,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  branch_type,
    input  logic        ula_zero,
    input  logic        ula_gt,
    input  logic        exc_req,
    input  logic [1:0]  exc_cause,
    input  logic [7:0]  mem_data_byte,
    output logic [31:0] pc_out,
    output logic [31:0] epc_out,
    output logic        exc_busy,
    output logic [31:0] exc_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        LOAD = 2'b10
    } state_t;

    localparam logic [3:0]  LAT_INIT    = 4'(MEM_LAT - 1);
    localparam logic [31:0] EXC_BASE_W  = 32'(EXC_BASE);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] epc_reg, epc_next;
    logic [1:0]  cause_reg, cause_next;
    logic [3:0]  count_reg, count_next;

    logic cond;
    logic pc_en;

    always_comb begin
        cond = 1'b0;
        case (branch_type)
            2'b00: cond = ula_zero;
            2'b01: cond = ~ula_zero;
            2'b10: cond = ula_gt;
            2'b11: cond = ~ula_gt;
            default: cond = 1'b0;
        endcase
    end

    assign pc_en = pc_write | (pc_write_cond & cond);

`ifdef PC_MISALIGN_EN
    logic misalign;
    assign misalign = pc_en & (mux_pc_source_out[1:0] != 2'b00);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            epc_reg   <= '0;
            cause_reg <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            epc_reg   <= epc_next;
            cause_reg <= cause_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        epc_next   = epc_reg;
        cause_next = cause_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                // An external request outranks both PC writes and the misalign trap.
                if (exc_req) begin
                    epc_next   = pc_reg - 32'd4;
                    cause_next = exc_cause;
                    count_next = LAT_INIT;
                    state_next = WAIT;
                end
`ifdef PC_MISALIGN_EN
                else if (misalign) begin
                    epc_next   = pc_reg - 32'd4;
                    cause_next = 2'b11;
                    count_next = LAT_INIT;
                    state_next = WAIT;
                end
`endif
                else if (pc_en) begin
                    pc_next = mux_pc_source_out;
                end
            end
            WAIT: begin
                if (count_reg == 4'd0) begin
                    state_next = LOAD;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            LOAD: begin
                pc_next    = {24'b0, mem_data_byte};
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign pc_out   = pc_reg;
    assign epc_out  = epc_reg;
    assign exc_busy = (state_reg == WAIT) || (state_reg == LOAD);
    assign exc_addr = exc_busy ? (EXC_BASE_W + {30'b0, cause_reg}) : 32'd0;

endmodule

// File: tb/tb_pc_epc_unit.sv
// Scoreboard bench for pc_epc_unit (EXC_BASE=253, MEM_LAT=2); misalign checks follow PC_MISALIGN_EN.
module tb_pc_epc_unit;

    logic        clk;
    logic        reset;
    logic [31:0] mux_pc_source_out;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  branch_type;
    logic        ula_zero;
    logic        ula_gt;
    logic        exc_req;
    logic [1:0]  exc_cause;
    logic [7:0]  mem_data_byte;
    logic [31:0] pc_out;
    logic [31:0] epc_out;
    logic        exc_busy;
    logic [31:0] exc_addr;

    pc_epc_unit #(.EXC_BASE(253), .MEM_LAT(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .mux_pc_source_out(mux_pc_source_out),
        .pc_write         (pc_write),
        .pc_write_cond    (pc_write_cond),
        .branch_type      (branch_type),
        .ula_zero         (ula_zero),
        .ula_gt           (ula_gt),
        .exc_req          (exc_req),
        .exc_cause        (exc_cause),
        .mem_data_byte    (mem_data_byte),
        .pc_out           (pc_out),
        .epc_out          (epc_out),
        .exc_busy         (exc_busy),
        .exc_addr         (exc_addr)
    );

    typedef struct packed {
        logic        pw;
        logic        pwc;
        logic [1:0]  bt;
        logic        z;
        logic        gt;
        logic        er;
        logic [1:0]  cause;
        logic [7:0]  mem;
        logic [31:0] mux;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        busy;
        logic [31:0] addr;
    } obs_t;

    obs_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(logic pw, logic pwc, logic [1:0] bt, logic z, logic gt,
                                 logic er, logic [1:0] cause, logic [7:0] mem, logic [31:0] mux);
        stim_t s;
        s.pw = pw; s.pwc = pwc; s.bt = bt; s.z = z; s.gt = gt;
        s.er = er; s.cause = cause; s.mem = mem; s.mux = mux;
        return s;
    endfunction

    function automatic obs_t ob(logic [31:0] pc, logic [31:0] epc, logic busy, logic [31:0] addr);
        obs_t o;
        o.pc = pc; o.epc = epc; o.busy = busy; o.addr = addr;
        return o;
    endfunction

    function automatic obs_t sample();
        return ob(pc_out, epc_out, exc_busy, exc_addr);
    endfunction

    task automatic drive(input stim_t s);
        pc_write          = s.pw;
        pc_write_cond     = s.pwc;
        branch_type       = s.bt;
        ula_zero          = s.z;
        ula_gt            = s.gt;
        exc_req           = s.er;
        exc_cause         = s.cause;
        mem_data_byte     = s.mem;
        mux_pc_source_out = s.mux;
    endtask

    task automatic test_reset();
        obs_t got, e;
        drive(mk(0, 0, 2'b00, 0, 0, 0, 2'b00, 8'h00, 32'h0));
        reset = 1'b1;
        #3 reset = 1'b0;
        sb.push_back(ob(32'h0, 32'h0, 1'b0, 32'h0));
        #1;
        got = sample();
        e = sb.pop_front();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset: got pc=%h epc=%h busy=%b addr=%h, want pc=%h epc=%h busy=%b addr=%h",
                     got.pc, got.epc, got.busy, got.addr, e.pc, e.epc, e.busy, e.addr);
        end else $display("reset: pc=%h epc=%h busy=%b addr=%h ok", got.pc, got.epc, got.busy, got.addr);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_uncond_write();
        stim_t st[3];
        obs_t  ex[3];
        obs_t  got, e;
        st[0] = mk(1, 0, 2'b00, 0, 0, 0, 2'b00, 8'h00, 32'h0000_0004); ex[0] = ob(32'h4,  32'h0, 0, 32'h0);
        st[1] = mk(0, 1, 2'b00, 0, 0, 0, 2'b00, 8'h00, 32'h0000_0080); ex[1] = ob(32'h4,  32'h0, 0, 32'h0);
        st[2] = mk(0, 1, 2'b00, 1, 0, 0, 2'b00, 8'h00, 32'h0000_0010); ex[2] = ob(32'h10, 32'h0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = sample();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL uncond_write[%0d]: got pc=%h epc=%h busy=%b addr=%h, want pc=%h epc=%h busy=%b addr=%h",
                         i, got.pc, got.epc, got.busy, got.addr, e.pc, e.epc, e.busy, e.addr);
            end else $display("uncond_write[%0d]: pc=%h ok", i, got.pc);
        end
    endtask

    task automatic test_cond_branch();
        stim_t st[4];
        obs_t  ex[4];
        obs_t  got, e;
        st[0] = mk(0, 1, 2'b01, 0, 0, 0, 2'b00, 8'h00, 32'h40);  ex[0] = ob(32'h40,  32'h0, 0, 32'h0);
        st[1] = mk(0, 1, 2'b11, 0, 1, 0, 2'b00, 8'h00, 32'h90);  ex[1] = ob(32'h40,  32'h0, 0, 32'h0);
        st[2] = mk(0, 1, 2'b10, 0, 0, 0, 2'b00, 8'h00, 32'h70);  ex[2] = ob(32'h40,  32'h0, 0, 32'h0);
        st[3] = mk(0, 1, 2'b10, 0, 1, 0, 2'b00, 8'h00, 32'h108); ex[3] = ob(32'h108, 32'h0, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = sample();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL cond_branch[%0d]: got pc=%h epc=%h busy=%b addr=%h, want pc=%h epc=%h busy=%b addr=%h",
                         i, got.pc, got.epc, got.busy, got.addr, e.pc, e.epc, e.busy, e.addr);
            end else $display("cond_branch[%0d]: pc=%h ok", i, got.pc);
        end
    endtask

    // Entry, busy masking of writes/requests, vector load, then a write in the first IDLE cycle.
    task automatic test_exception();
        stim_t st[5];
        obs_t  ex[5];
        obs_t  got, e;
        st[0] = mk(1, 0, 2'b00, 0, 0, 1, 2'b01, 8'h00, 32'h300); ex[0] = ob(32'h108, 32'h104, 1, 32'hFE);
        st[1] = mk(1, 0, 2'b00, 0, 0, 1, 2'b10, 8'h00, 32'h200); ex[1] = ob(32'h108, 32'h104, 1, 32'hFE);
        st[2] = mk(1, 0, 2'b00, 0, 0, 1, 2'b10, 8'h80, 32'h200); ex[2] = ob(32'h108, 32'h104, 1, 32'hFE);
        st[3] = mk(1, 0, 2'b00, 0, 0, 1, 2'b10, 8'h80, 32'h200); ex[3] = ob(32'h80,  32'h104, 0, 32'h0);
        st[4] = mk(1, 0, 2'b00, 0, 0, 0, 2'b00, 8'h00, 32'h84);  ex[4] = ob(32'h84,  32'h104, 0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = sample();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL exception[%0d]: got pc=%h epc=%h busy=%b addr=%h, want pc=%h epc=%h busy=%b addr=%h",
                         i, got.pc, got.epc, got.busy, got.addr, e.pc, e.epc, e.busy, e.addr);
            end else $display("exception[%0d]: pc=%h epc=%h busy=%b addr=%h ok", i, got.pc, got.epc, got.busy, got.addr);
        end
    endtask

    // Reserved cause 3 vectors to 256; busy must last exactly MEM_LAT+1 cycles.
    task automatic test_latency();
        obs_t got, e;
        int   cnt;
        drive(mk(0, 0, 2'b00, 0, 0, 1, 2'b11, 8'h3C, 32'h0));
        sb.push_back(ob(32'h84, 32'h80, 1, 32'h100));
        @(posedge clk); #1;
        got = sample();
        e = sb.pop_front();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL latency_entry: got pc=%h epc=%h busy=%b addr=%h, want pc=%h epc=%h busy=%b addr=%h",
                     got.pc, got.epc, got.busy, got.addr, e.pc, e.epc, e.busy, e.addr);
        end else $display("latency_entry: epc=%h addr=%h ok", got.epc, got.addr);
        exc_req = 1'b0;
        cnt = 0;
        while (exc_busy === 1'b1 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        n_checks++;
        if (cnt != 3) begin
            n_fail++;
            $display("FAIL latency_busy_cycles: got %0d, want 3", cnt);
        end else $display("latency_busy_cycles: %0d ok", cnt);
        sb.push_back(ob(32'h3C, 32'h80, 0, 32'h0));
        got = sample();
        e = sb.pop_front();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL latency_load: got pc=%h epc=%h busy=%b addr=%h, want pc=%h epc=%h busy=%b addr=%h",
                     got.pc, got.epc, got.busy, got.addr, e.pc, e.epc, e.busy, e.addr);
        end else $display("latency_load: pc=%h ok", got.pc);
    endtask

    // Reset mid-exception, then an exception from pc=0 to exercise EPC wraparound.
    task automatic test_async_reset();
        stim_t st[4];
        obs_t  ex[4];
        obs_t  got, e;
        st[0] = mk(1, 0, 2'b00, 0, 0, 0, 2'b00, 8'h00, 32'h40); ex[0] = ob(32'h40, 32'h80, 0, 32'h0);
        st[1] = mk(0, 0, 2'b00, 0, 0, 1, 2'b10, 8'h00, 32'h0);  ex[1] = ob(32'h40, 32'h3C, 1, 32'hFF);
        for (int i = 0; i < 2; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = sample();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL async_pre[%0d]: got pc=%h epc=%h busy=%b addr=%h, want pc=%h epc=%h busy=%b addr=%h",
                         i, got.pc, got.epc, got.busy, got.addr, e.pc, e.epc, e.busy, e.addr);
            end else $display("async_pre[%0d]: pc=%h epc=%h busy=%b ok", i, got.pc, got.epc, got.busy);
        end
        #1 reset = 1'b0;
        sb.push_back(ob(32'h0, 32'h0, 0, 32'h0));
        #1;
        got = sample();
        e = sb.pop_front();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL async_reset: got pc=%h epc=%h busy=%b addr=%h, want pc=%h epc=%h busy=%b addr=%h",
                     got.pc, got.epc, got.busy, got.addr, e.pc, e.epc, e.busy, e.addr);
        end else $display("async_reset: cleared ok");
        @(negedge clk);
        reset = 1'b1;
        st[0] = mk(0, 0, 2'b00, 0, 0, 1, 2'b00, 8'h00, 32'h0); ex[0] = ob(32'h0, 32'hFFFF_FFFC, 1, 32'hFD);
        st[1] = mk(0, 0, 2'b00, 0, 0, 0, 2'b00, 8'h08, 32'h0); ex[1] = ob(32'h0, 32'hFFFF_FFFC, 1, 32'hFD);
        st[2] = mk(0, 0, 2'b00, 0, 0, 0, 2'b00, 8'h08, 32'h0); ex[2] = ob(32'h0, 32'hFFFF_FFFC, 1, 32'hFD);
        st[3] = mk(0, 0, 2'b00, 0, 0, 0, 2'b00, 8'h08, 32'h0); ex[3] = ob(32'h8, 32'hFFFF_FFFC, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = sample();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL async_wrap[%0d]: got pc=%h epc=%h busy=%b addr=%h, want pc=%h epc=%h busy=%b addr=%h",
                         i, got.pc, got.epc, got.busy, got.addr, e.pc, e.epc, e.busy, e.addr);
            end else $display("async_wrap[%0d]: pc=%h epc=%h busy=%b ok", i, got.pc, got.epc, got.busy);
        end
    endtask

    task automatic test_misalign();
        stim_t st[5];
        obs_t  ex[5];
        obs_t  got, e;
        int    n;
        st[0] = mk(1, 0, 2'b00, 0, 0, 0, 2'b00, 8'h00, 32'h20); ex[0] = ob(32'h20, 32'hFFFF_FFFC, 0, 32'h0);
`ifdef PC_MISALIGN_EN
        n = 5;
        st[1] = mk(1, 0, 2'b00, 0, 0, 0, 2'b00, 8'h00, 32'h22); ex[1] = ob(32'h20, 32'h1C, 1, 32'h100);
        st[2] = mk(0, 0, 2'b00, 0, 0, 0, 2'b00, 8'h44, 32'h0);  ex[2] = ob(32'h20, 32'h1C, 1, 32'h100);
        st[3] = mk(0, 0, 2'b00, 0, 0, 0, 2'b00, 8'h44, 32'h0);  ex[3] = ob(32'h20, 32'h1C, 1, 32'h100);
        st[4] = mk(0, 0, 2'b00, 0, 0, 0, 2'b00, 8'h44, 32'h0);  ex[4] = ob(32'h44, 32'h1C, 0, 32'h0);
`else
        n = 3;
        st[1] = mk(1, 0, 2'b00, 0, 0, 0, 2'b00, 8'h00, 32'h22); ex[1] = ob(32'h22, 32'hFFFF_FFFC, 0, 32'h0);
        st[2] = mk(1, 0, 2'b00, 0, 0, 0, 2'b00, 8'h00, 32'h23); ex[2] = ob(32'h23, 32'hFFFF_FFFC, 0, 32'h0);
        st[3] = st[2]; ex[3] = ex[2];
        st[4] = st[2]; ex[4] = ex[2];
`endif
        for (int i = 0; i < n; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = sample();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL misalign[%0d]: got pc=%h epc=%h busy=%b addr=%h, want pc=%h epc=%h busy=%b addr=%h",
                         i, got.pc, got.epc, got.busy, got.addr, e.pc, e.epc, e.busy, e.addr);
            end else $display("misalign[%0d]: pc=%h epc=%h busy=%b addr=%h ok", i, got.pc, got.epc, got.busy, got.addr);
        end
    endtask

    initial begin
        test_reset();
        test_uncond_write();
        test_cond_branch();
        test_exception();
        test_latency();
        test_async_reset();
        test_misalign();
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule
